// File: rtl/fb_arb_pkg.sv
// Shared constants and types for the framebuffer access arbiter.
// Covers state encodings, default geometry, XGA screen size and the grant priority helper.
package fb_arb_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DRAW = 2'd2;

    localparam int ADDR_W_DEF    = 20;
    localparam int DATA_W_DEF    = 16;
    localparam int BURST_LEN_DEF = 16;

    localparam int H_ACTIVE = 1024;
    localparam int V_ACTIVE = 768;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_SCAN = 2'd1,
        GRANT_DRAW = 2'd2
    } grant_e;

    // Scan normally wins. The caller sets draw_first at the end of a burst
    // so that a waiting draw gets one guaranteed slot.
    function automatic grant_e pick_grant(input logic scan_req,
                                          input logic draw_req,
                                          input logic draw_first);
        if (draw_first && draw_req) return GRANT_DRAW;
        if (scan_req)               return GRANT_SCAN;
        if (draw_req)               return GRANT_DRAW;
        return GRANT_NONE;
    endfunction

endpackage

// File: rtl/fb_access_arbiter_if.sv
// Bundle of the requester, RAM and status signals around the framebuffer arbiter.
// The slave modport is the arbiter's view; the master modport is the view of the surrounding logic.
interface fb_access_arbiter_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
);
    logic              scan_req;
    logic [ADDR_W-1:0] scan_addr;
    logic              scan_ack;
    logic [DATA_W-1:0] scan_rdata;
    logic              scan_rvalid;
    logic              scan_last;

    logic              draw_req;
    logic [ADDR_W-1:0] draw_addr;
    logic [DATA_W-1:0] draw_wdata;
    logic              draw_ack;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;
    logic [15:0]       draw_stall_cnt;

    modport slave (
        input  scan_req, scan_addr, draw_req, draw_addr, draw_wdata, mem_rdata,
        output scan_ack, scan_rdata, scan_rvalid, scan_last, draw_ack,
               mem_en, mem_we, mem_addr, mem_wdata, busy, draw_stall_cnt
    );

    modport master (
        output scan_req, scan_addr, draw_req, draw_addr, draw_wdata, mem_rdata,
        input  scan_ack, scan_rdata, scan_rvalid, scan_last, draw_ack,
               mem_en, mem_we, mem_addr, mem_wdata, busy, draw_stall_cnt
    );

endinterface

// File: rtl/fb_arb_rd_pipe.sv
// Read-return pipeline: follows each issued read beat through the one-cycle RAM latency.
// It registers mem_rdata into scan_rdata, scan_rvalid and scan_last. Reset flushes it asynchronously.
module fb_arb_rd_pipe #(
    parameter int DATA_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              issue_i,
    input  logic              issue_last_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [DATA_W-1:0] scan_rdata_o,
    output logic              scan_rvalid_o,
    output logic              scan_last_o
);

    logic              inflight_q;
    logic              inflight_last_q;
    logic              rvalid_q;
    logic              last_q;
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            rvalid_q        <= 1'b0;
            last_q          <= 1'b0;
            rdata_q         <= '0;
        end else begin
            inflight_q      <= issue_i;
            inflight_last_q <= issue_i & issue_last_i;
            rvalid_q        <= inflight_q;
            last_q          <= inflight_last_q;
            // scan_rdata keeps the last returned word between bursts
            if (inflight_q) rdata_q <= mem_rdata_i;
        end
    end

    assign scan_rdata_o  = rdata_q;
    assign scan_rvalid_o = rvalid_q;
    assign scan_last_o   = last_q;

endmodule

// File: rtl/fb_access_arbiter.sv
// Arbiter for the single-port XGA framebuffer. Scan-out read bursts have priority over single draw writes.
// Optional macro FB_ARB_STATS_EN adds a saturating draw stall counter.
//
// state | meaning
// IDLE  | no access in progress, RAM disabled
// SCAN  | issuing a BURST_LEN-word read burst, one beat per cycle
// DRAW  | issuing one draw write (single cycle)
module fb_access_arbiter
    import fb_arb_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int BURST_LEN = BURST_LEN_DEF
) (
    input  logic               CLOCK_50,
    input  logic               reset_n,
    fb_access_arbiter_if.slave bus
);

    localparam int BEAT_W = $clog2(BURST_LEN);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [BEAT_W-1:0] PRE_LAST  = BEAT_W'(BURST_LEN - 2);

    logic [1:0]        state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              scan_ack_q, scan_ack_d;
    logic              draw_ack_q, draw_ack_d;
    logic              busy_q, busy_d;
    logic              rd_last_q, rd_last_d;
    logic              at_decision;
    grant_e            grant;

    always_comb begin
        // A new grant is chosen only at the edge that ends the current access,
        // so consecutive accesses run back to back without a bubble.
        at_decision = (state_q != ST_SCAN) || (beat_q == LAST_BEAT);
        grant       = pick_grant(bus.scan_req, bus.draw_req, state_q == ST_SCAN);

        state_d     = state_q;
        beat_d      = beat_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        scan_ack_d  = 1'b0;
        draw_ack_d  = 1'b0;
        rd_last_d   = 1'b0;

        if (!at_decision) begin
            beat_d     = beat_q + 1'b1;
            mem_en_d   = 1'b1;
            mem_addr_d = mem_addr_q + 1'b1;
            rd_last_d  = (beat_q == PRE_LAST);
        end else begin
            unique case (grant)
                GRANT_SCAN: begin
                    state_d    = ST_SCAN;
                    beat_d     = '0;
                    mem_en_d   = 1'b1;
                    mem_addr_d = bus.scan_addr;
                    scan_ack_d = 1'b1;
                end
                GRANT_DRAW: begin
                    state_d     = ST_DRAW;
                    mem_en_d    = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = bus.draw_addr;
                    mem_wdata_d = bus.draw_wdata;
                    draw_ack_d  = 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            scan_ack_q  <= 1'b0;
            draw_ack_q  <= 1'b0;
            busy_q      <= 1'b0;
            rd_last_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            scan_ack_q  <= scan_ack_d;
            draw_ack_q  <= draw_ack_d;
            busy_q      <= busy_d;
            rd_last_q   <= rd_last_d;
        end
    end

    fb_arb_rd_pipe #(.DATA_W(DATA_W)) u_rd_pipe (
        .clk_i         (CLOCK_50),
        .rst_n_i       (reset_n),
        .issue_i       (mem_en_q & ~mem_we_q),
        .issue_last_i  (rd_last_q),
        .mem_rdata_i   (bus.mem_rdata),
        .scan_rdata_o  (bus.scan_rdata),
        .scan_rvalid_o (bus.scan_rvalid),
        .scan_last_o   (bus.scan_last)
    );

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.scan_ack  = scan_ack_q;
    assign bus.draw_ack  = draw_ack_q;
    assign bus.busy      = busy_q;

`ifdef FB_ARB_STATS_EN
    logic [15:0] stall_q;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= '0;
        end else if (bus.draw_req && !draw_ack_q && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign bus.draw_stall_cnt = stall_q;
`else
    assign bus.draw_stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_fb_access_arbiter.sv
// Scoreboard bench for fb_access_arbiter. A transaction-level reference model queues the expected outputs for each cycle.
// A negedge monitor compares them. Directed scenarios are followed by a randomized two-requester phase.
module tb_fb_access_arbiter;
    import fb_arb_pkg::*;

    localparam int AW = 20;
    localparam int DW = 16;
    localparam int BL = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fb_access_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bif();

    fb_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL)) dut (
        .CLOCK_50 (clk),
        .reset_n  (rst_n),
        .bus      (bif)
    );

    typedef struct packed {
        logic          en;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          sack;
        logic          dack;
        logic          rvalid;
        logic [DW-1:0] rdata;
        logic          last;
        logic          busy;
        logic [15:0]   stall;
    } obs_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    obs_t exp_q[$];
    logic [DW-1:0] env_mem [bit [AW-1:0]];
    logic [DW-1:0] ref_mem [bit [AW-1:0]];

    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
        return a[15:0] ^ {a[19:16], 12'h5A3};
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.en = bif.mem_en;       o.we = bif.mem_we;
        o.addr = bif.mem_addr;   o.wdata = bif.mem_wdata;
        o.sack = bif.scan_ack;   o.dack = bif.draw_ack;
        o.rvalid = bif.scan_rvalid; o.rdata = bif.scan_rdata;
        o.last = bif.scan_last;  o.busy = bif.busy;
        o.stall = bif.draw_stall_cnt;
        return o;
    endfunction

    task automatic check_obs(input string name, input obs_t a, input obs_t e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s t=%0t actual: en=%b we=%b addr=%h wd=%h sack=%b dack=%b rv=%b rd=%h last=%b busy=%b stall=%0d required: en=%b we=%b addr=%h wd=%h sack=%b dack=%b rv=%b rd=%h last=%b busy=%b stall=%0d",
                     name, $time, a.en, a.we, a.addr, a.wdata, a.sack, a.dack, a.rvalid, a.rdata, a.last, a.busy, a.stall,
                     e.en, e.we, e.addr, e.wdata, e.sack, e.dack, e.rvalid, e.rdata, e.last, e.busy, e.stall);
        end
    endtask

    task automatic check_val(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic check_le(input string name, input int act, input int bound);
        checks++;
        if (act > bound) begin
            errors++;
            $display("FAIL %s actual=%0d required<=%0d", name, act, bound);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Framebuffer RAM: one-cycle read latency, write on the enable cycle.
    initial begin : ram_proc
        logic en, we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bif.mem_rdata = '0;
        forever begin
            @(negedge clk);
            en = bif.mem_en; we = bif.mem_we; a = bif.mem_addr; d = bif.mem_wdata;
            @(posedge clk);
            #1;
            if (en && we) env_mem[a] = d;
            else if (en) bif.mem_rdata = env_mem.exists(a) ? env_mem[a] : init_word(a);
        end
    end

    // Reference model: at every edge it decides which access occupies the next cycle,
    // then queues the outputs expected during that cycle.
    initial begin : model_proc
        obs_t cur, nxt;
        int op;
        int beat;
        logic [AW-1:0] base, waddr;
        logic [DW-1:0] wdat;
        logic pend_v, pend_l, cur_last;
        logic [DW-1:0] pend_d;
        logic [15:0] stall;
        op = 0; beat = 0; base = '0; waddr = '0; wdat = '0;
        pend_v = 0; pend_l = 0; pend_d = '0; cur_last = 0; stall = '0; cur = '0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                op = 0; beat = 0; pend_v = 0; pend_l = 0; cur_last = 0; stall = '0; cur = '0;
                exp_q.push_back(cur);
                continue;
            end
`ifdef FB_ARB_STATS_EN
            if (bif.draw_req && !cur.dack && stall != 16'hFFFF) stall = stall + 16'd1;
`endif
            nxt = '0;
            nxt.stall  = stall;
            nxt.rvalid = pend_v;
            nxt.last   = pend_v & pend_l;
            nxt.rdata  = pend_v ? pend_d : cur.rdata;
            pend_v = cur.en && !cur.we;
            pend_l = cur_last;
            pend_d = ref_mem.exists(cur.addr) ? ref_mem[cur.addr] : init_word(cur.addr);

            if (op == 1 && beat != BL - 1) begin
                beat++;
            end else begin
                if (op == 1 && bif.draw_req) op = 2;
                else if (bif.scan_req) begin op = 1; beat = 0; base = bif.scan_addr; end
                else if (bif.draw_req) op = 2;
                else op = 0;
                if (op == 2) begin waddr = bif.draw_addr; wdat = bif.draw_wdata; end
            end

            nxt.addr  = cur.addr;
            nxt.wdata = cur.wdata;
            cur_last  = 0;
            if (op == 1) begin
                nxt.en = 1; nxt.busy = 1;
                nxt.addr = AW'(base + AW'(beat));
                nxt.sack = (beat == 0);
                cur_last = (beat == BL - 1);
            end else if (op == 2) begin
                nxt.en = 1; nxt.we = 1; nxt.busy = 1; nxt.dack = 1;
                nxt.addr = waddr; nxt.wdata = wdat;
                ref_mem[waddr] = wdat;
            end
            exp_q.push_back(nxt);
            cur = nxt;
        end
    end

    initial begin : monitor_proc
        obs_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0) continue;
            e = exp_q.pop_front();
            check_obs("cycle", sample(), e);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic do_scan(input logic [AW-1:0] a, input int withdraw_pct);
        int n;
        n = 0;
        bif.scan_req = 1'b1;
        bif.scan_addr = a;
        forever begin
            tick();
            if (bif.scan_ack) break;
            if (withdraw_pct > 0 && $urandom_range(99) < withdraw_pct) begin
                bif.scan_req = 1'b0;
                return;
            end
            n++;
            if (n > 60) begin
                checks++; errors++;
                $display("FAIL scan_ack_timeout actual=none required=ack within 60 cycles");
                break;
            end
        end
        bif.scan_req = 1'b0;
    endtask

    task automatic do_draw(input logic [AW-1:0] a, input logic [DW-1:0] d, input int withdraw_pct);
        int t0;
        int n;
        n = 0;
        t0 = cyc;
        bif.draw_req = 1'b1;
        bif.draw_addr = a;
        bif.draw_wdata = d;
        forever begin
            tick();
            if (bif.draw_ack) begin
                check_le("draw_wait", cyc - t0, BL + 1);
                break;
            end
            if (withdraw_pct > 0 && $urandom_range(99) < withdraw_pct) begin
                bif.draw_req = 1'b0;
                return;
            end
            n++;
            if (n > 60) begin
                checks++; errors++;
                $display("FAIL draw_ack_timeout actual=none required=ack within 60 cycles");
                break;
            end
        end
        bif.draw_req = 1'b0;
    endtask

    initial begin : stim_proc
        int t_end;
        bif.scan_req = 0; bif.scan_addr = '0;
        bif.draw_req = 0; bif.draw_addr = '0; bif.draw_wdata = '0;
        idle(3);
        rst_n = 1'b1;
        idle(2);

        do_scan(20'h00100, 0);
        idle(20);

        do_draw(20'h12345, 16'hBEEF, 0);
        idle(3);
        check_val("ram_0x12345", int'(env_mem.exists(20'h12345) ? env_mem[20'h12345] : 16'h0), 16'hBEEF);

        fork
            do_scan(20'h00200, 0);
            do_draw(20'h00ABC, 16'h1234, 0);
        join
        idle(20);

        t_end = cyc + 200;
        fork
            while (cyc < t_end) do_scan(AW'($urandom), 0);
            while (cyc < t_end) do_draw(AW'($urandom_range(16'hFFFF)), DW'($urandom), 0);
        join
        idle(20);

        do_scan(20'hFFFF8, 0);
        idle(20);

        bif.scan_req = 1'b1;
        bif.scan_addr = 20'h00400;
        begin : wait_ack
            for (int i = 0; i < 10; i++) begin
                tick();
                if (bif.scan_ack) disable wait_ack;
            end
            checks++; errors++;
            $display("FAIL reset_scan_ack actual=none required=ack");
        end
        bif.scan_req = 1'b0;
        idle(5);
        rst_n = 1'b0;
        #1;
        check_obs("reset_async", sample(), '0);
        idle(2);
        rst_n = 1'b1;
        idle(4);
        do_scan(20'h00500, 0);
        idle(20);

        t_end = cyc + 1500;
        fork
            while (cyc < t_end) begin
                idle($urandom_range(4));
                if (cyc < t_end) do_scan(AW'($urandom_range(12'hFFF)), 10);
            end
            while (cyc < t_end) begin
                idle($urandom_range(3));
                if (cyc < t_end) do_draw(AW'($urandom_range(12'hFFF)), DW'($urandom), 10);
            end
        join
        idle(30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
